// File: rtl/core_pkg.sv
// core_pkg: shared core-wide constants and types.
//   PC_W          - program-counter width (word-addressed)
//   INSTR_W       - instruction word width
//   RESET_PC      - first fetch address after reset
//   fetch_state_t - instruction-fetch controller FSM states
package core_pkg;

    localparam int unsigned PC_W     = 16;
    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned RESET_PC = 10;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDiscard
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO of {instr, pc} with a registered head.
//   i_clk, i_rst_n               - clock, async active-low reset
//   i_push, i_push_instr/_pc     - write one entry
//   i_pop                        - drop the head entry
//   i_flush                      - empty the FIFO (wins over push/pop)
//   o_full, o_empty, o_count     - occupancy
//   o_head_valid/_instr/_pc      - registered head entry
module fetch_fifo
    import core_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned PC_W  = core_pkg::PC_W
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [INSTR_W-1:0]         i_push_instr,
    input  logic [PC_W-1:0]            i_push_pc,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_head_valid,
    output logic [INSTR_W-1:0]         o_head_instr,
    output logic [PC_W-1:0]            o_head_pc
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [INSTR_W-1:0] r_mem_instr [DEPTH];
    logic [PC_W-1:0]    r_mem_pc    [DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr, r_wr_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_pop, w_push, w_bypass;
    logic [PTR_W-1:0]   w_rd_ptr_nxt;
    logic [CNT_W-1:0]   w_count_nxt;
    logic [INSTR_W-1:0] w_head_instr;
    logic [PC_W-1:0]    w_head_pc;

    always_comb begin
        w_pop        = i_pop && (r_count != '0) && !i_flush;
        w_push       = i_push && !i_flush && ((r_count < DEPTH_C) || w_pop);
        w_rd_ptr_nxt = w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
        w_count_nxt  = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 1'b1;
        end
        // Nothing left behind the head: the pushed word becomes the head directly.
        w_bypass     = w_pop ? (r_count == CNT_W'(1)) : (r_count == '0);
        w_head_instr = w_bypass ? i_push_instr : r_mem_instr[w_rd_ptr_nxt];
        w_head_pc    = w_bypass ? i_push_pc    : r_mem_pc[w_rd_ptr_nxt];
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_instr[r_wr_ptr] <= i_push_instr;
            r_mem_pc[r_wr_ptr]    <= i_push_pc;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            o_head_valid <= 1'b0;
            o_head_instr <= '0;
            o_head_pc    <= '0;
        end else if (i_flush) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            o_head_valid <= 1'b0;
        end else if (w_push || w_pop) begin
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_wr_ptr     <= w_push ? r_wr_ptr + 1'b1 : r_wr_ptr;
            r_count      <= w_count_nxt;
            o_head_valid <= (w_count_nxt != '0);
            if (w_count_nxt != '0) begin
                o_head_instr <= w_head_instr;
                o_head_pc    <= w_head_pc;
            end
        end
    end

    assign o_full  = (r_count == DEPTH_C);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch controller between the pipeline and the icache.
//   i_clk, i_rst_n                  - clock, async active-low reset
//   i_clk_en                        - global enable; low freezes all state
//   o_ic_clk_en, o_ic_read_addr     - one-cycle icache read strobe and address
//   i_ic_read_data, i_ic_data_ready - icache response
//   o_instr_valid/_instr/_instr_pc  - buffered instruction towards decode
//   i_instr_ready                   - decode accepts the head
//   i_redirect, i_redirect_pc       - flush and restart fetch at a new PC
module fetch_ctrl
    import core_pkg::*;
#(
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned PC_W     = core_pkg::PC_W,
    parameter int unsigned RESET_PC = core_pkg::RESET_PC,
    parameter int unsigned DEPTH    = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_clk_en,
    output logic               o_ic_clk_en,
    output logic [ADDR_W-1:0]  o_ic_read_addr,
    input  logic [INSTR_W-1:0] i_ic_read_data,
    input  logic               i_ic_data_ready,
    output logic               o_instr_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [PC_W-1:0]    o_instr_pc,
    input  logic               i_instr_ready,
    input  logic               i_redirect,
    input  logic [PC_W-1:0]    i_redirect_pc
);

    localparam int unsigned CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_state_t     r_state;
    logic [PC_W-1:0]  r_fetch_pc;
    logic             r_ic_clk_en;

    logic             w_flush, w_pop, w_push, w_full, w_empty, w_slot_after_push;
    logic [CNT_W-1:0] w_count, w_occ_after;
    logic [PC_W-1:0]  w_pc_inc, w_tgt_pc;

    always_comb begin
        w_flush           = i_clk_en && i_redirect;
        w_pop             = i_clk_en && !i_redirect && !w_empty && i_instr_ready;
        w_push            = i_clk_en && !i_redirect && (r_state == StWait) && i_ic_data_ready;
        w_pc_inc          = r_fetch_pc + 1'b1;
        w_tgt_pc          = i_redirect ? i_redirect_pc : r_fetch_pc;
        // WAIT reserved a slot, so count+1 never exceeds DEPTH here.
        w_occ_after       = w_pop ? w_count : w_count + 1'b1;
        w_slot_after_push = (w_occ_after < DEPTH_C);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= StIdle;
            r_fetch_pc     <= PC_W'(RESET_PC);
            r_ic_clk_en    <= 1'b0;
            o_ic_read_addr <= '0;
        end else if (i_clk_en) begin
            r_ic_clk_en <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_redirect || !w_full) begin
                        r_fetch_pc     <= w_tgt_pc;
                        r_state        <= StIssue;
                        r_ic_clk_en    <= 1'b1;
                        o_ic_read_addr <= w_tgt_pc[ADDR_W-1:0];
                    end
                end
                StIssue: begin
                    if (i_redirect) begin
                        r_fetch_pc     <= i_redirect_pc;
                        r_ic_clk_en    <= 1'b1;
                        o_ic_read_addr <= i_redirect_pc[ADDR_W-1:0];
                    end else begin
                        r_state <= StWait;
                    end
                end
                StWait: begin
                    if (i_redirect) begin
                        r_fetch_pc <= i_redirect_pc;
                        if (i_ic_data_ready) begin
                            r_state        <= StIssue;
                            r_ic_clk_en    <= 1'b1;
                            o_ic_read_addr <= i_redirect_pc[ADDR_W-1:0];
                        end else begin
                            r_state <= StDiscard;
                        end
                    end else if (i_ic_data_ready) begin
                        r_fetch_pc <= w_pc_inc;
                        if (w_slot_after_push) begin
                            r_state        <= StIssue;
                            r_ic_clk_en    <= 1'b1;
                            o_ic_read_addr <= w_pc_inc[ADDR_W-1:0];
                        end else begin
                            r_state <= StIdle;
                        end
                    end
                end
                StDiscard: begin
                    r_fetch_pc <= w_tgt_pc;
                    if (i_ic_data_ready) begin
                        r_state        <= StIssue;
                        r_ic_clk_en    <= 1'b1;
                        o_ic_read_addr <= w_tgt_pc[ADDR_W-1:0];
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // The strobe must not reach the cache while the core is frozen.
    assign o_ic_clk_en = r_ic_clk_en && i_clk_en;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .PC_W  (PC_W)
    ) u_fifo (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_push       (w_push),
        .i_push_instr (i_ic_read_data),
        .i_push_pc    (r_fetch_pc),
        .i_pop        (w_pop),
        .i_flush      (w_flush),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_count      (w_count),
        .o_head_valid (o_instr_valid),
        .o_head_instr (o_instr),
        .o_head_pc    (o_instr_pc)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized bench for fetch_ctrl with a transaction-level reference model
// (expected fetch/decode PC streams, buffer occupancy) and a behavioural icache responder.
module tb_fetch_ctrl;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n, clk_en, ic_ready, instr_ready, redirect;
    logic [31:0] ic_data;
    logic [15:0] rpc;
    logic        ic_clk_en, instr_valid;
    logic [5:0]  ic_addr;
    logic [31:0] instr;
    logic [15:0] instr_pc;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .ADDR_W   (6),
        .PC_W     (16),
        .RESET_PC (10),
        .DEPTH    (DEPTH)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_clk_en        (clk_en),
        .o_ic_clk_en     (ic_clk_en),
        .o_ic_read_addr  (ic_addr),
        .i_ic_read_data  (ic_data),
        .i_ic_data_ready (ic_ready),
        .o_instr_valid   (instr_valid),
        .o_instr         (instr),
        .o_instr_pc      (instr_pc),
        .i_instr_ready   (instr_ready),
        .i_redirect      (redirect),
        .i_redirect_pc   (rpc)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Icache contents
    logic [31:0] mem [64];

    // Reference model: next PC decode should see, next PC to be fetched, buffered count
    logic [15:0] exp_pc, exp_issue;
    int          occ;
    bit          outstanding, stale;
    int          strobes, delivered, cyc, first_strobe;

    // Responder and knobs
    int          resp_wait;
    bit          resp_hold;
    logic [5:0]  resp_addr;
    int          p_en, p_rdy, p_redir, lat_max, freeze_left;
    bit          freeze_on_strobe;

    // Previous-cycle sample for freeze checks
    bit          prev_en;
    logic        s_valid;
    logic [31:0] s_instr;
    logic [15:0] s_pc;
    logic [5:0]  s_addr;

    task automatic reset_model();
        exp_pc      = 16'd10;
        exp_issue   = 16'd10;
        occ         = 0;
        outstanding = 0;
        stale       = 0;
        resp_wait   = 0;
        resp_hold   = 0;
        prev_en     = 1;
        freeze_left = 0;
    endtask

    task automatic run_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            if (freeze_left > 0) begin
                clk_en = 1'b0;
                freeze_left--;
            end else begin
                clk_en = ($urandom_range(99) < p_en);
            end
            if (resp_wait > 0) begin
                resp_wait--;
                if (resp_wait == 0) resp_hold = 1;
            end
            ic_ready    = resp_hold;
            ic_data     = resp_hold ? mem[resp_addr] : $urandom;
            instr_ready = ($urandom_range(99) < p_rdy);
            case ($urandom_range(3))
                0:       rpc = 16'hFFFF;
                1:       rpc = 16'h0030;
                default: rpc = 16'($urandom);
            endcase
            #1;
            // Never redirect during a live strobe cycle: the cache model keeps one request.
            redirect = !ic_clk_en && (($urandom_range(99) < p_redir) ||
                                      (ic_ready && p_redir > 0 && $urandom_range(99) < 25));
            @(negedge clk);
            if (!prev_en) begin
                check_eq("frz_valid", instr_valid, s_valid);
                check_eq("frz_instr", instr, s_instr);
                check_eq("frz_pc", instr_pc, s_pc);
                check_eq("frz_addr", ic_addr, s_addr);
            end
            if (!clk_en) check_eq("strobe_gated", ic_clk_en, 0);
            check_eq("valid_vs_occ", instr_valid, occ != 0);
            if (clk_en) begin
                if (ic_clk_en) begin
                    check_eq("one_outstanding", outstanding, 0);
                    check_eq("slot_free", occ < DEPTH, 1);
                    check_eq("strobe_addr", ic_addr, exp_issue[5:0]);
                    if (first_strobe < 0) first_strobe = cyc;
                    outstanding = 1;
                    exp_issue++;
                    strobes++;
                    resp_addr = ic_addr;
                    resp_wait = $urandom_range(lat_max, 1);
                    if (freeze_on_strobe) begin
                        freeze_left      = 5;
                        freeze_on_strobe = 0;
                    end
                end
                if (instr_valid && instr_ready && !redirect) begin
                    check_eq("deliv_pc", instr_pc, exp_pc);
                    check_eq("deliv_instr", instr, mem[exp_pc[5:0]]);
                    exp_pc++;
                    occ--;
                    delivered++;
                end
                if (ic_ready) begin
                    outstanding = 0;
                    resp_hold   = 0;
                    if (redirect || stale) stale = 0;
                    else occ++;
                end
                if (redirect) begin
                    occ       = 0;
                    exp_pc    = rpc;
                    exp_issue = rpc;
                    stale     = outstanding;
                end
            end
            prev_en = clk_en;
            s_valid = instr_valid;
            s_instr = instr;
            s_pc    = instr_pc;
            s_addr  = ic_addr;
            cyc++;
        end
    endtask

    initial begin
        int  d0;
        bit  found;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        rst_n = 1'b0; clk_en = 1'b0; ic_ready = 1'b0; ic_data = '0;
        instr_ready = 1'b0; redirect = 1'b0; rpc = '0;
        strobes = 0; delivered = 0; cyc = 0; first_strobe = -1;
        freeze_on_strobe = 0;
        reset_model();
        #3;
        check_eq("rst_valid", instr_valid, 0);
        check_eq("rst_instr", instr, 0);
        check_eq("rst_pc", instr_pc, 0);
        check_eq("rst_strobe", ic_clk_en, 0);
        check_eq("rst_addr", ic_addr, 0);

        // Decode stalled: two fetches fill the buffer, then fetch stops
        p_en = 100; p_rdy = 0; p_redir = 0; lat_max = 1;
        run_cycles(12);
        check_eq("startup_cycle", first_strobe, 1);
        check_eq("stall_strobes", strobes, 2);
        check_eq("stall_valid", instr_valid, 1);
        check_eq("stall_pc", instr_pc, 16'h000A);

        // Drain and resume
        p_rdy = 100;
        run_cycles(12);
        check_eq("drain_progress", delivered >= 6, 1);

        // Freeze five cycles right after a strobe with the response held
        freeze_on_strobe = 1;
        d0 = delivered;
        run_cycles(16);
        check_eq("freeze_progress", delivered > d0, 1);

        // Random traffic with redirects, freezes and variable latency
        p_en = 85; p_rdy = 70; p_redir = 6; lat_max = 3;
        d0 = delivered;
        run_cycles(3000);
        check_eq("random_progress", delivered - d0 > 200, 1);

        // Reset in the middle of WAIT with a valid head
        @(posedge clk); #1; rst_n = 1'b0; redirect = 1'b0; ic_ready = 1'b0;
        reset_model();
        p_en = 100; p_rdy = 0; p_redir = 0; lat_max = 3;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            run_cycles(1);
            found = (occ == 1) && outstanding && !resp_hold;
        end
        check_eq("reach_wait", found, 1);
        #2; rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", instr_valid, 0);
        check_eq("mid_rst_pc", instr_pc, 0);
        check_eq("mid_rst_addr", ic_addr, 0);
        reset_model();
        ic_ready = 1'b0;

        // Restart from RESET_PC
        p_en = 90; p_rdy = 80; p_redir = 4; lat_max = 2;
        d0 = delivered;
        run_cycles(300);
        check_eq("restart_progress", delivered - d0 > 20, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
